// File: rtl/mine_state_controller_if.sv
// Scan-side and result signals exchanged between the minefield renderer and the
// mine state controller.
interface mine_state_controller_if;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        vsync;
    logic        mine_gfx;
    logic [3:0]  mine_index;
    logic        tank1_gfx;
    logic        tank2_gfx;
    logic        rearm;
    logic [15:0] mine_exploded;
    logic        hit_p1;
    logic        hit_p2;
    logic        explode_gfx;
    logic        field_clear;

    modport master (
        output hpos, vpos, display_on, vsync, mine_gfx, mine_index,
        output tank1_gfx, tank2_gfx, rearm,
        input  mine_exploded, hit_p1, hit_p2, explode_gfx, field_clear
    );

    modport slave (
        input  hpos, vpos, display_on, vsync, mine_gfx, mine_index,
        input  tank1_gfx, tank2_gfx, rearm,
        output mine_exploded, hit_p1, hit_p2, explode_gfx, field_clear
    );
endinterface

// File: rtl/mine_state_controller.sv
// Per-mine exploded state: collects tank/mine pixel overlaps during the scan,
// commits them at each frame edge and drives the flashing explosion overlay.
module mine_state_controller #(
    parameter int unsigned EXPLODE_FRAMES = 30,
    parameter int unsigned FLASH_BIT      = 1
) (
    input logic                    clk,
    input logic                    reset,
    mine_state_controller_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExploding, StClear} state_e;

    localparam logic [7:0] TimerLoad = 8'(EXPLODE_FRAMES);
    localparam logic [2:0] FlashSel  = 3'(FLASH_BIT);

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] exploded_q, exploded_d;
    logic [15:0] pending1_q, pending1_d;
    logic [15:0] pending2_q, pending2_d;
    logic [11:0] hit_cell_q, hit_cell_d;
    logic        hit_seen_q, hit_seen_d;
    logic [11:0] cell_q, cell_d;
    logic        hit_p1_q, hit_p1_d;
    logic        hit_p2_q, hit_p2_d;
    logic        gfx_q, gfx_d;
    logic        vsync_q;

    logic        c1, c2;
    logic        frame_edge;
    logic [11:0] scan_cell;
    logic [15:0] commit_bits;
    logic        new_hit;

    assign c1          = bus.display_on & bus.mine_gfx & bus.tank1_gfx;
    assign c2          = bus.display_on & bus.mine_gfx & bus.tank2_gfx;
    assign frame_edge  = bus.vsync & ~vsync_q;
    assign scan_cell   = {bus.hpos[8:3], bus.vpos[8:3]};
    assign commit_bits = pending1_q | pending2_q;
    assign new_hit     = |(commit_bits & ~exploded_q);

    // Explosion FSM; the cell shown is the one captured during the committing frame.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cell_d  = cell_q;
        case (state_q)
            StIdle: begin
                if (frame_edge && new_hit) begin
                    state_d = StExploding;
                    timer_d = TimerLoad;
                    cell_d  = hit_cell_q;
                end
            end
            StExploding: begin
                if (frame_edge) begin
                    if (new_hit) begin
                        timer_d = TimerLoad;
                        cell_d  = hit_cell_q;
                    end else if (timer_q <= 8'd1) begin
                        timer_d = 8'd0;
                        state_d = (&exploded_q) ? StClear : StIdle;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            StClear: begin
                state_d = StClear;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (bus.rearm) begin
            state_d = StIdle;
            timer_d = 8'd0;
            cell_d  = 12'd0;
        end
    end

    // Hit accumulation and per-frame commit; rearm overrides a coincident frame edge.
    always_comb begin
        exploded_d  = exploded_q;
        pending1_d  = pending1_q;
        pending2_d  = pending2_q;
        hit_cell_d  = hit_cell_q;
        hit_seen_d  = hit_seen_q;
        frame_cnt_d = frame_cnt_q;
        hit_p1_d    = 1'b0;
        hit_p2_d    = 1'b0;
        if (bus.rearm) begin
            exploded_d = 16'd0;
            pending1_d = 16'd0;
            pending2_d = 16'd0;
            hit_cell_d = 12'd0;
            hit_seen_d = 1'b0;
        end else if (frame_edge) begin
            exploded_d  = exploded_q | commit_bits;
            hit_p1_d    = |pending1_q;
            hit_p2_d    = |pending2_q;
            pending1_d  = 16'd0;
            pending2_d  = 16'd0;
            hit_seen_d  = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            if (c1) pending1_d[bus.mine_index] = 1'b1;
            if (c2) pending2_d[bus.mine_index] = 1'b1;
            if ((c1 || c2) && !hit_seen_q) begin
                hit_cell_d = scan_cell;
                hit_seen_d = 1'b1;
            end
        end
        gfx_d = !bus.rearm && (state_q == StExploding) && bus.display_on &&
                (scan_cell == cell_q) && frame_cnt_q[FlashSel];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            timer_q     <= 8'd0;
            cell_q      <= 12'd0;
            exploded_q  <= 16'd0;
            pending1_q  <= 16'd0;
            pending2_q  <= 16'd0;
            hit_cell_q  <= 12'd0;
            hit_seen_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            hit_p1_q    <= 1'b0;
            hit_p2_q    <= 1'b0;
            gfx_q       <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cell_q      <= cell_d;
            exploded_q  <= exploded_d;
            pending1_q  <= pending1_d;
            pending2_q  <= pending2_d;
            hit_cell_q  <= hit_cell_d;
            hit_seen_q  <= hit_seen_d;
            frame_cnt_q <= frame_cnt_d;
            hit_p1_q    <= hit_p1_d;
            hit_p2_q    <= hit_p2_d;
            gfx_q       <= gfx_d;
            vsync_q     <= bus.vsync;
        end
    end

    assign bus.mine_exploded = exploded_q;
    assign bus.hit_p1        = hit_p1_q;
    assign bus.hit_p2        = hit_p2_q;
    assign bus.explode_gfx   = gfx_q;
    assign bus.field_clear   = (state_q == StClear);

endmodule

// File: tb/tb_mine_state_controller.sv
// Randomized and directed bench for mine_state_controller against a frame-level model.
module tb_mine_state_controller;

    localparam int unsigned EXPLODE_FRAMES = 30;
    localparam int unsigned FLASH_BIT      = 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mine_state_controller_if bus ();

    mine_state_controller #(
        .EXPLODE_FRAMES (EXPLODE_FRAMES),
        .FLASH_BIT      (FLASH_BIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: explosion active while m_timer > 0, field cleared once m_clr is set.
    bit [15:0] m_exp, m_p1, m_p2;
    bit        m_h1, m_h2, m_gfx, m_clr, m_seen, m_vs;
    int        m_timer, m_frames;
    bit [11:0] m_cap, m_cell;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = '0; m_p1 = '0; m_p2 = '0;
        m_h1 = 0; m_h2 = 0; m_gfx = 0; m_clr = 0; m_seen = 0; m_vs = 0;
        m_timer = 0; m_frames = 0; m_cap = '0; m_cell = '0;
    endtask

    task automatic model_step();
        bit        c1, c2, edge_now;
        bit [11:0] sc;
        bit [15:0] newb;
        c1 = bus.display_on && bus.mine_gfx && bus.tank1_gfx;
        c2 = bus.display_on && bus.mine_gfx && bus.tank2_gfx;
        edge_now = bus.vsync && !m_vs;
        sc = {bus.hpos[8:3], bus.vpos[8:3]};
        m_gfx = !bus.rearm && (m_timer > 0) && bus.display_on && (sc == m_cell) &&
                (((m_frames >> FLASH_BIT) & 1) == 1);
        m_h1 = 0;
        m_h2 = 0;
        if (bus.rearm) begin
            m_exp = '0; m_p1 = '0; m_p2 = '0; m_timer = 0; m_clr = 0;
            m_cell = '0; m_cap = '0; m_seen = 0;
        end else if (edge_now) begin
            newb  = (m_p1 | m_p2) & ~m_exp;
            m_exp = m_exp | m_p1 | m_p2;
            m_h1  = (m_p1 != 0);
            m_h2  = (m_p2 != 0);
            m_frames = (m_frames + 1) % 256;
            if (newb != 0) begin
                m_timer = EXPLODE_FRAMES;
                m_cell  = m_cap;
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0 && m_exp == 16'hFFFF) m_clr = 1;
            end
            m_p1 = '0; m_p2 = '0; m_seen = 0;
        end else begin
            if (c1) m_p1[bus.mine_index] = 1'b1;
            if (c2) m_p2[bus.mine_index] = 1'b1;
            if ((c1 || c2) && !m_seen) begin
                m_cap  = sc;
                m_seen = 1;
            end
        end
        m_vs = bus.vsync;
    endtask

    task automatic compare_all();
        check_eq("mine_exploded", bus.mine_exploded, m_exp);
        check_eq("hit_p1", 16'(bus.hit_p1), 16'(m_h1));
        check_eq("hit_p2", 16'(bus.hit_p2), 16'(m_h2));
        check_eq("explode_gfx", 16'(bus.explode_gfx), 16'(m_gfx));
        check_eq("field_clear", 16'(bus.field_clear), 16'(m_clr));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pix(input int h, input int v, input bit disp, input bit mg, input int idx,
                       input bit t1, input bit t2);
        bus.hpos       = 9'(h);
        bus.vpos       = 9'(v);
        bus.display_on = disp;
        bus.mine_gfx   = mg;
        bus.mine_index = 4'(idx);
        bus.tank1_gfx  = t1;
        bus.tank2_gfx  = t2;
        bus.vsync      = 1'b0;
        bus.rearm      = 1'b0;
        tick();
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Two vsync cycles: the first is the rising edge, the second must not re-commit.
    task automatic vsync_pulse();
        pix(0, 0, 0, 0, 0, 0, 0);
        bus.vsync = 1'b1;
        tick();
        tick();
        bus.vsync = 1'b0;
    endtask

    task automatic do_rearm();
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
    endtask

    // Empty frames with the scan sitting on a given pixel so the overlay is observed.
    task automatic watch_frames(input int n, input int h, input int v);
        for (int f = 0; f < n; f++) begin
            pix(h, v, 1, 0, 0, 0, 0);
            pix(h + 1, v, 1, 0, 0, 0, 0);
            pix(h + 16, v, 1, 0, 0, 0, 0);
            vsync_pulse();
        end
    endtask

    initial begin
        int fc_wait;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.hpos = '0; bus.vpos = '0; bus.display_on = 0; bus.vsync = 0; bus.mine_gfx = 0;
        bus.mine_index = '0; bus.tank1_gfx = 0; bus.tank2_gfx = 0; bus.rearm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_exploded", bus.mine_exploded, 16'h0000);
        check_eq("reset_field_clear", 16'(bus.field_clear), 16'h0);
        check_eq("reset_gfx", 16'(bus.explode_gfx), 16'h0);
        reset = 1'b1;

        // Player 1 on mine 5 for three pixels at (96, 88).
        blank(2);
        for (int i = 0; i < 3; i++) pix(96 + i, 88, 1, 1, 5, 1, 0);
        pix(0, 0, 0, 0, 0, 0, 0);
        bus.vsync = 1'b1;
        tick();
        check_eq("t1_exploded", bus.mine_exploded, 16'h0020);
        check_eq("t1_hit_p1", 16'(bus.hit_p1), 16'h1);
        check_eq("t1_hit_p2", 16'(bus.hit_p2), 16'h0);
        tick();
        bus.vsync = 1'b0;
        check_eq("t1_hit_p1_single", 16'(bus.hit_p1), 16'h0);
        watch_frames(6, 96, 88);

        // Both tanks on mine 2 in the same frame.
        do_rearm();
        pix(40, 40, 1, 1, 2, 1, 1);
        pix(0, 0, 0, 0, 0, 0, 0);
        bus.vsync = 1'b1;
        tick();
        check_eq("t2_exploded", bus.mine_exploded, 16'h0004);
        check_eq("t2_both_pulse", {15'd0, bus.hit_p1 & bus.hit_p2}, 16'h1);
        tick();
        bus.vsync = 1'b0;

        // Mine 0, ten frames, then mine 9 restarts the explosion at a new cell.
        do_rearm();
        pix(16, 24, 1, 1, 0, 0, 1);
        vsync_pulse();
        watch_frames(10, 16, 24);
        pix(200, 120, 1, 1, 9, 1, 0);
        pix(16, 24, 1, 0, 0, 0, 0);
        vsync_pulse();
        check_eq("t3_exploded", bus.mine_exploded, 16'h0201);
        watch_frames(8, 200, 120);
        watch_frames(23, 16, 24);
        watch_frames(2, 200, 120);
        check_eq("t3_gfx_after", 16'(bus.explode_gfx), 16'h0);

        // All sixteen mines over four frames, then wait out the timer.
        do_rearm();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) pix(8 * (f * 4 + k), 64, 1, 1, f * 4 + k, k[0], ~k[0]);
            vsync_pulse();
        end
        check_eq("t5_all_exploded", bus.mine_exploded, 16'hFFFF);
        fc_wait = 0;
        while (!bus.field_clear && fc_wait < 40) begin
            watch_frames(1, 96, 64);
            fc_wait++;
        end
        check_eq("t5_field_clear", 16'(bus.field_clear), 16'h1);
        watch_frames(2, 96, 64);
        pix(0, 0, 0, 0, 0, 0, 0);
        bus.vsync = 1'b1;
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
        check_eq("t5_rearm_exploded", bus.mine_exploded, 16'h0000);
        check_eq("t5_rearm_clear", 16'(bus.field_clear), 16'h0);
        check_eq("t5_rearm_no_pulse", {14'd0, bus.hit_p1, bus.hit_p2}, 16'h0);
        tick();
        bus.vsync = 1'b0;

        // Twelve mines exploding, then asynchronous reset mid-explosion.
        for (int k = 4; k < 16; k++) pix(8 * k, 100, 1, 1, k, 1, 0);
        vsync_pulse();
        watch_frames(2, 32, 100);
        check_eq("t6_pre_reset", bus.mine_exploded, 16'hFFF0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_exploded", bus.mine_exploded, 16'h0000);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        blank(2);

        // Randomized frames over a small set of cells so overlay hits are frequent.
        for (int f = 0; f < 300; f++) begin
            int npix;
            npix = int'($urandom_range(4, 12));
            for (int p = 0; p < npix; p++) begin
                int idx;
                bit mg;
                idx = int'($urandom_range(0, 15));
                mg  = ($urandom_range(0, 2) == 0) && !m_exp[idx];
                bus.hpos       = 9'(64 + 8 * $urandom_range(0, 2) + $urandom_range(0, 7));
                bus.vpos       = 9'(32 + 8 * $urandom_range(0, 1) + $urandom_range(0, 7));
                bus.display_on = ($urandom_range(0, 7) != 0);
                bus.mine_gfx   = mg;
                bus.mine_index = 4'(idx);
                bus.tank1_gfx  = ($urandom_range(0, 5) == 0);
                bus.tank2_gfx  = ($urandom_range(0, 5) == 0);
                bus.vsync      = 1'b0;
                bus.rearm      = ($urandom_range(0, 199) == 0);
                tick();
            end
            bus.rearm = 1'b0;
            vsync_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mine_state_controller.md
Name: mine_state_controller

Overview:
- Write side of the minefield's per-mine exploded state: detects tank sprites overlapping live mine pixels during the scan and commits those hits once per frame.
- Drives the 16-bit mine_exploded vector that masks mine rendering, per-player hit pulses for the tank controllers, and a flashing explosion overlay for the video mixer.
- Sits beside the minefield renderer in the tank game top level, on the pixel clock.

Parameters:
- EXPLODE_FRAMES, 30, number of frames the explosion overlay stays active after a commit (1..255).
- FLASH_BIT, 1, bit of the frame counter that gates overlay flashing (0..7).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  9  current horizontal pixel position
- vpos  in  9  current vertical pixel position
- display_on  in  1  visible-area qualifier
- vsync  in  1  vertical sync from the sync generator
- mine_gfx  in  1  live (unexploded) mine pixel
- mine_index  in  4  index of the mine owning the current scanline slice
- tank1_gfx  in  1  player 1 tank pixel
- tank2_gfx  in  1  player 2 tank pixel
- rearm  in  1  synchronous pulse; restores all mines
- mine_exploded  out  16  one bit per mine, 1 = exploded
- hit_p1  out  1  one-cycle pulse: player 1 hit a mine last frame
- hit_p2  out  1  one-cycle pulse: player 2 hit a mine last frame
- explode_gfx  out  1  explosion overlay pixel
- field_clear  out  1  all 16 mines exploded

Behaviour:
- Reset (reset=0, async):
  - mine_exploded=0, pending1=0, pending2=0, hit_p1=0, hit_p2=0, explode_gfx=0, field_clear=0.
  - Timer=0, frame counter=0, captured cell=0, vsync_q=0, state=IDLE.
- Collision detect, combinational:
  - c1 = display_on & mine_gfx & tank1_gfx.
  - c2 = display_on & mine_gfx & tank2_gfx.
  - On a clk edge with c1, set pending1[mine_index]; with c2, set pending2[mine_index].
  - Both tanks on the same pixel set both pending vectors.
- Cell capture:
  - The first c1|c2 pixel of a frame latches cell = {hpos[8:3], vpos[8:3]}.
  - Later hits in the same frame do not overwrite the cell.
- Frame edge:
  - frame_edge = vsync & ~vsync_q, with vsync_q registered each clk.
  - On the frame_edge clk:
    - mine_exploded <= mine_exploded | pending1 | pending2.
    - hit_p1 <= |pending1 and hit_p2 <= |pending2; each is high for exactly that one following cycle.
    - Pending vectors cleared; frame counter increments (8-bit, wraps 255->0).
  - A collision on the same clk as frame_edge is dropped; this is unreachable in practice because display_on=0 during vsync.
- State machine, evaluated on frame_edge only:
  - IDLE: if the commit adds any new bit, load timer=EXPLODE_FRAMES and go to EXPLODING.
  - EXPLODING:
    - New hits reload the timer and take the newly captured cell (restart).
    - Otherwise the timer decrements; at 1 -> 0 go to IDLE, or to CLEAR if mine_exploded is all ones.
  - CLEAR: field_clear=1; stays until rearm.
  - A commit that completes all 16 bits goes through EXPLODING before CLEAR.
- explode_gfx, registered with 1-cycle latency versus hpos/vpos:
  - High when state=EXPLODING & display_on & {hpos[8:3], vpos[8:3]} == cell & frame_counter[FLASH_BIT].
- Rearm:
  - Synchronous, takes priority over everything on the same clk including frame_edge.
  - Clears mine_exploded, pending vectors, timer and cell; state=IDLE; field_clear=0; no hit pulses.
- Already-exploded mines produce no collisions because mine_gfx is pre-masked; no bit is ever cleared except by rearm or reset.
- Reset asserted mid-frame or mid-explosion returns to reset values immediately.

Test Plan:
- Player 1 overlaps mine 5 for 3 pixels at hpos 96, vpos 88, then frame edge -> next cycle mine_exploded=16'h0020, hit_p1=1 for one cycle, hit_p2=0, state EXPLODING, timer=30.
- Both tanks hit mine 2 in the same frame -> mine_exploded=16'h0004; hit_p1 and hit_p2 both pulse on the same cycle.
- Hit mine 0, wait 10 frames, hit mine 9 -> timer reloads to 30, cell moves to the mine 9 location, mine_exploded=16'h0201; after 30 more frames with no hits, state returns to IDLE and explode_gfx=0.
- Explosion active, frame counter bit 1 toggling -> explode_gfx is high only at the captured cell and only on frames with counter bit 1 set.
- Hit all 16 mines over several frames -> after the last timer expiry field_clear=1; pulse rearm together with a frame edge -> mine_exploded=0, field_clear=0, no hit pulse.
- Pull reset low mid-explosion with mine_exploded=16'hFFF0 -> all outputs 0 asynchronously, before the next clk edge.
